multicycle_control: RTL and testbench
=====================================

# multicycle_control

Control unit for the multicycle RV32I datapath. It sits directly upstream of the ALU and drives `i_alu_control`, the ALU operand selects, and every datapath write strobe. It sequences each instruction through a Moore state machine and evaluates the ALU `o_zero` flag for `beq`. Supported instructions are lw, sw, R-type, I-type ALU, beq and jal. Memory accesses wait on a ready handshake.

## Interface
Parameters: none.

Ports:
- i_clk  in  1  clock; all state changes on the rising edge
- i_rst_n  in  1  reset; asynchronous assertion, active-low
- i_op  in  7  instruction opcode from the instruction register
- i_funct3  in  3  instruction funct3
- i_funct7b5  in  1  instruction bit 30
- i_zero  in  1  zero flag from the ALU
- i_mem_ready  in  1  memory has completed the current access
- o_pc_write  out  1  PC register load enable
- o_adr_src  out  1  memory address select: 0 = PC, 1 = Result
- o_mem_write  out  1  memory write strobe
- o_ir_write  out  1  instruction register and oldPC load enable
- o_reg_write  out  1  register file write strobe
- o_result_src  out  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult
- o_alu_src_a  out  2  ALU A select: 00 = PC, 01 = oldPC, 10 = rs1 register
- o_alu_src_b  out  2  ALU B select: 00 = rs2 register, 01 = ImmExt, 10 = constant 4
- o_imm_src  out  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J
- o_alu_control  out  3  000 = ADD, 001 = SUB, 010 = AND, 011 = OR, 101 = SLT
- o_state  out  4  current state code, for debug

## Operation
State codes:
- 0 FETCH, 1 DECODE, 2 MEMADR, 3 MEMREAD, 4 MEMWB, 5 MEMWRITE
- 6 EXECUTER, 7 EXECUTEI, 8 ALUWB, 9 BEQ, 10 JAL

Transitions:
- FETCH→DECODE when i_mem_ready = 1; otherwise stay in FETCH.
- DECODE branches on i_op:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECUTER
  - 0010011 → EXECUTEI
  - 1100011 → BEQ
  - 1101111 → JAL
  - any other opcode → FETCH (executes as a NOP)
- MEMADR → MEMREAD if i_op = 0000011, else → MEMWRITE.
- MEMREAD → MEMWB when i_mem_ready = 1; otherwise stay.
- MEMWRITE → FETCH when i_mem_ready = 1; otherwise stay.
- EXECUTER, EXECUTEI and JAL → ALUWB.
- MEMWB, ALUWB and BEQ → FETCH.

Outputs per state (any field not listed is 0):
- FETCH: alu_src_b = 10, result_src = 10. ir_write and pc_update are asserted only in a cycle with i_mem_ready = 1.
- DECODE: alu_src_a = 01, alu_src_b = 01, aluop = 00. This computes the branch/jump target.
- MEMADR: alu_src_a = 10, alu_src_b = 01, aluop = 00.
- MEMREAD: adr_src = 1.
- MEMWB: result_src = 01, reg_write = 1.
- MEMWRITE: adr_src = 1. mem_write is held at 1 for every cycle spent in the state.
- EXECUTER: alu_src_a = 10, aluop = 10.
- EXECUTEI: alu_src_a = 10, alu_src_b = 01, aluop = 10.
- ALUWB: reg_write = 1.
- BEQ: alu_src_a = 10, aluop = 01, branch = 1.
- JAL: alu_src_a = 01, alu_src_b = 10, pc_update = 1.

Derived signals:
- o_pc_write = pc_update | (branch & i_zero).
- o_imm_src is decoded combinationally from i_op in every state:
  - 0100011 → 01
  - 1100011 → 10
  - 1101111 → 11
  - all other opcodes → 00

ALU decode (from the internal aluop):
- aluop 00 → ADD; aluop 01 → SUB.
- aluop 10 decodes on funct3:
  - 000 → SUB if (i_op[5] & i_funct7b5), else ADD
  - 010 → SLT
  - 110 → OR
  - 111 → AND
  - any other funct3 → ADD
- aluop 11 → ADD.

## Timing
- All outputs are combinational from the state register plus i_op, funct fields, i_zero and i_mem_ready. There are no output registers.
- Reset:
  - Asserting i_rst_n = 0 forces state to FETCH immediately.
  - While i_rst_n = 0, o_pc_write, o_ir_write, o_mem_write and o_reg_write are forced to 0.
  - All other outputs take their FETCH values: alu_src_b = 10, result_src = 10, alu_control = 000, o_state = 0.
- Reset asserted mid-instruction aborts it. No write strobe is asserted after assertion. Fetch restarts on the first edge after release.
- Latency in cycles, with i_mem_ready held at 1:
  - lw 5; sw 4; R-type 4; I-type 4; jal 4; beq 3; unsupported opcode 2.
- Every cycle i_mem_ready is low in FETCH, MEMREAD or MEMWRITE adds exactly one cycle. No strobe other than mem_write is asserted during the wait.
- BEQ samples i_zero in the same cycle it is in the state, so a taken branch loads the PC at the exiting edge.

## Test plan
- Reset mid-MEMWRITE:
  - Drive i_rst_n = 0 asynchronously → o_state = 0 and o_mem_write = 0 before the next clock edge.
  - Release reset with ready = 1 → o_ir_write = 1 on the first cycle.
- lw (i_op = 0000011), ready = 1:
  - o_state goes 0, 1, 2, 3, 4, 0.
  - o_reg_write = 1 only in state 4, with result_src = 01.
  - o_alu_control = 000 in MEMADR.
- R-type funct3 = 000, funct7b5 = 1 → o_alu_control = 001 in EXECUTER.
  - funct3 = 010 → 101; funct3 = 111 → 010; funct3 = 110 → 011.
  - I-type (0010011) with funct7b5 = 1 and funct3 = 000 → 000 (ADD).
- beq:
  - i_zero = 1 in BEQ → o_pc_write = 1 for that cycle.
  - i_zero = 0 → o_pc_write = 0.
  - Both cases return to FETCH after 3 cycles total.
- sw with i_mem_ready low for 2 cycles in MEMWRITE:
  - o_mem_write = 1 for 3 cycles; total instruction takes 6 cycles.
  - o_reg_write stays 0 throughout.
- jal:
  - o_state goes 0, 1, 10, 8, 0.
  - o_pc_write = 1 in JAL; o_reg_write = 1 in ALUWB; o_imm_src = 11.
- Opcode 0000000 → DECODE returns to FETCH; no write strobes asserted.

Source files
------------

// File: rtl/multicycle_control.sv
// Multicycle RV32I control unit: Moore sequencer, ALU decode and write strobes.
// Outputs are combinational from the state register and instruction fields.
module multicycle_control (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [6:0] i_op,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7b5,
    input  logic       i_zero,
    input  logic       i_mem_ready,
    output logic       o_pc_write,
    output logic       o_adr_src,
    output logic       o_mem_write,
    output logic       o_ir_write,
    output logic       o_reg_write,
    output logic [1:0] o_result_src,
    output logic [1:0] o_alu_src_a,
    output logic [1:0] o_alu_src_b,
    output logic [1:0] o_imm_src,
    output logic [2:0] o_alu_control,
    output logic [3:0] o_state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_e;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    state_e state_q;
    state_e state_d;

    logic       pc_update;
    logic       branch;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] aluop;
    logic [2:0] alu_control;
    logic [1:0] imm_src;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: begin
                if (i_mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                case (i_op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECUTER;
                    OP_I:         state_d = S_EXECUTEI;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                state_d = (i_op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                if (i_mem_ready) state_d = S_MEMWB;
            end
            S_MEMWRITE: begin
                if (i_mem_ready) state_d = S_FETCH;
            end
            S_EXECUTER, S_EXECUTEI, S_JAL: state_d = S_ALUWB;
            S_MEMWB, S_ALUWB, S_BEQ:       state_d = S_FETCH;
            default:                       state_d = S_FETCH;
        endcase
    end

    always_comb begin
        pc_update  = 1'b0;
        branch     = 1'b0;
        adr_src    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        result_src = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        aluop      = 2'b00;
        case (state_q)
            S_FETCH: begin
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write   = i_mem_ready;
                pc_update  = i_mem_ready;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
            end
            S_EXECUTER: begin
                alu_src_a = 2'b10;
                aluop     = 2'b10;
            end
            S_EXECUTEI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                aluop     = 2'b10;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
            end
            S_BEQ: begin
                alu_src_a = 2'b10;
                aluop     = 2'b01;
                branch    = 1'b1;
            end
            S_JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_update = 1'b1;
            end
            default: begin
                alu_src_b  = 2'b10;
                result_src = 2'b10;
            end
        endcase
    end

    // op[5] separates R-type SUB from I-type ADDI with imm bit 30 set
    always_comb begin
        alu_control = ALU_ADD;
        case (aluop)
            2'b01: alu_control = ALU_SUB;
            2'b10: begin
                case (i_funct3)
                    3'b000: begin
                        alu_control = (i_op[5] & i_funct7b5) ? ALU_SUB : ALU_ADD;
                    end
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

    always_comb begin
        case (i_op)
            OP_SW:   imm_src = 2'b01;
            OP_BEQ:  imm_src = 2'b10;
            OP_JAL:  imm_src = 2'b11;
            default: imm_src = 2'b00;
        endcase
    end

    // strobes are held low for the whole time reset is asserted
    assign o_pc_write    = i_rst_n & (pc_update | (branch & i_zero));
    assign o_ir_write    = i_rst_n & ir_write;
    assign o_mem_write   = i_rst_n & mem_write;
    assign o_reg_write   = i_rst_n & reg_write;
    assign o_adr_src     = adr_src;
    assign o_result_src  = result_src;
    assign o_alu_src_a   = alu_src_a;
    assign o_alu_src_b   = alu_src_b;
    assign o_alu_control = alu_control;
    assign o_imm_src     = imm_src;
    assign o_state       = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: random instruction streams with ready stalls
// compared against a per-instruction phase model, plus reset and stall cases.
module tb_multicycle_control;

    logic       i_clk = 1'b0;
    logic       i_rst_n;
    logic [6:0] i_op;
    logic [2:0] i_funct3;
    logic       i_funct7b5;
    logic       i_zero;
    logic       i_mem_ready;
    logic       o_pc_write;
    logic       o_adr_src;
    logic       o_mem_write;
    logic       o_ir_write;
    logic       o_reg_write;
    logic [1:0] o_result_src;
    logic [1:0] o_alu_src_a;
    logic [1:0] o_alu_src_b;
    logic [1:0] o_imm_src;
    logic [2:0] o_alu_control;
    logic [3:0] o_state;

    int n_chk = 0;
    int n_err = 0;

    multicycle_control dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_op         (i_op),
        .i_funct3     (i_funct3),
        .i_funct7b5   (i_funct7b5),
        .i_zero       (i_zero),
        .i_mem_ready  (i_mem_ready),
        .o_pc_write   (o_pc_write),
        .o_adr_src    (o_adr_src),
        .o_mem_write  (o_mem_write),
        .o_ir_write   (o_ir_write),
        .o_reg_write  (o_reg_write),
        .o_result_src (o_result_src),
        .o_alu_src_a  (o_alu_src_a),
        .o_alu_src_b  (o_alu_src_b),
        .o_imm_src    (o_imm_src),
        .o_alu_control(o_alu_control),
        .o_state      (o_state)
    );

    always #5 i_clk = ~i_clk;

    logic [15:0] got_v;
    assign got_v = {o_pc_write, o_adr_src, o_mem_write, o_ir_write,
                    o_reg_write, o_result_src, o_alu_src_a, o_alu_src_b,
                    o_alu_control, o_imm_src};

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Phase numbers are the state codes an instruction walks through.
    function automatic logic [15:0] exp_out(input int p, input logic rdy,
                                            input logic [6:0] op,
                                            input logic [2:0] f3,
                                            input logic f7,
                                            input logic z);
        logic       pcw, adr, mw, irw, rw;
        logic [1:0] rs, sa, sb, imm;
        logic [2:0] alu;
        pcw = 0; adr = 0; mw = 0; irw = 0; rw = 0;
        rs = 0; sa = 0; sb = 0; alu = 0;
        case (p)
            0: begin pcw = rdy; irw = rdy; rs = 2; sb = 2; end
            1: begin sa = 1; sb = 1; end
            2: begin sa = 2; sb = 1; end
            3: adr = 1;
            4: begin rs = 1; rw = 1; end
            5: begin adr = 1; mw = 1; end
            6: sa = 2;
            7: begin sa = 2; sb = 1; end
            8: rw = 1;
            9: begin sa = 2; pcw = z; alu = 3'd1; end
            10: begin sa = 1; sb = 2; pcw = 1; end
            default: ;
        endcase
        if (p == 6 || p == 7) begin
            if (f3 == 3'd0)      alu = (op[5] & f7) ? 3'd1 : 3'd0;
            else if (f3 == 3'd2) alu = 3'd5;
            else if (f3 == 3'd6) alu = 3'd3;
            else if (f3 == 3'd7) alu = 3'd2;
            else                 alu = 3'd0;
        end
        if (op == 7'h23)      imm = 2'd1;
        else if (op == 7'h63) imm = 2'd2;
        else if (op == 7'h6f) imm = 2'd3;
        else                  imm = 2'd0;
        return {pcw, adr, mw, irw, rw, rs, sa, sb, alu, imm};
    endfunction

    // Entered and left at posedge+1 with the DUT in FETCH.
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3,
                             input logic f7, input logic z, input int maxw);
        int  ph[$];
        int  nw;
        bit  waitable;
        case (op)
            7'h03:   ph = '{0, 1, 2, 3, 4};
            7'h23:   ph = '{0, 1, 2, 5};
            7'h33:   ph = '{0, 1, 6, 8};
            7'h13:   ph = '{0, 1, 7, 8};
            7'h63:   ph = '{0, 1, 9};
            7'h6f:   ph = '{0, 1, 10, 8};
            default: ph = '{0, 1};
        endcase
        i_op = op; i_funct3 = f3; i_funct7b5 = f7; i_zero = z;
        foreach (ph[k]) begin
            waitable = (ph[k] == 0 || ph[k] == 3 || ph[k] == 5);
            nw = (waitable && maxw > 0) ? $urandom_range(maxw, 0) : 0;
            for (int w = 0; w <= nw; w++) begin
                i_mem_ready = waitable ? (w == nw) : 1'($urandom);
                #2;
                check("state", 32'(o_state), 32'(ph[k]));
                check("outs", 32'(got_v),
                      32'(exp_out(ph[k], i_mem_ready, op, f3, f7, z)));
                @(posedge i_clk);
                #1;
            end
        end
    endtask

    task automatic sw_wait2();
        int cyc = 0, mw = 0, rw = 0, seen = 0;
        i_op = 7'h23;
        do begin
            if (o_state == 4'd5) begin
                i_mem_ready = (seen >= 2);
                seen++;
            end else begin
                i_mem_ready = 1'b1;
            end
            #2;
            mw += int'(o_mem_write);
            rw += int'(o_reg_write);
            cyc++;
            @(posedge i_clk);
            #1;
        end while (o_state != 4'd0 && cyc < 20);
        check("sw_cycles", 32'(cyc), 32'd6);
        check("sw_memwr", 32'(mw), 32'd3);
        check("sw_regwr", 32'(rw), 32'd0);
    endtask

    task automatic reset_mid_store();
        i_op = 7'h23;
        i_mem_ready = 1'b1;
        repeat (3) begin
            @(posedge i_clk);
            #1;
        end
        i_mem_ready = 1'b0;
        #2;
        check("pre_rst_state", 32'(o_state), 32'd5);
        check("pre_rst_mw", 32'(o_mem_write), 32'd1);
        #1;
        i_rst_n = 1'b0;
        i_op = 7'h00;
        i_mem_ready = 1'b1;
        #1;
        check("rst_state", 32'(o_state), 32'd0);
        check("rst_mw", 32'(o_mem_write), 32'd0);
        check("rst_outs", 32'(got_v), 32'(exp_out(0, 1'b0, 7'h00, i_funct3,
                                                   i_funct7b5, i_zero)));
        @(posedge i_clk);
        #1;
        check("rst_hold", 32'(got_v), 32'(exp_out(0, 1'b0, 7'h00, i_funct3,
                                                   i_funct7b5, i_zero)));
        i_rst_n = 1'b1;
        #2;
        check("rel_irw", 32'(o_ir_write), 32'd1);
        check("rel_state", 32'(o_state), 32'd0);
        @(posedge i_clk);
        #1;
        check("rel_dec", 32'(o_state), 32'd1);
        @(posedge i_clk);
        #1;
        check("rel_back", 32'(o_state), 32'd0);
    endtask

    logic [6:0] ops [8];

    initial begin
        ops = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6f, 7'h00, 7'h73};
        i_rst_n = 1'b0;
        i_op = 7'h33; i_funct3 = 3'd0; i_funct7b5 = 1'b1;
        i_zero = 1'b1; i_mem_ready = 1'b1;
        #3;
        check("reset_state", 32'(o_state), 32'd0);
        check("reset_outs", 32'(got_v),
              32'(exp_out(0, 1'b0, 7'h33, 3'd0, 1'b1, 1'b1)));
        @(posedge i_clk);
        #1;
        check("reset_held", 32'(o_state), 32'd0);
        i_rst_n = 1'b1;

        run_instr(7'h03, 3'd2, 1'b0, 1'b0, 0);
        run_instr(7'h33, 3'd0, 1'b1, 1'b0, 0);
        run_instr(7'h33, 3'd2, 1'b0, 1'b0, 0);
        run_instr(7'h33, 3'd7, 1'b0, 1'b0, 0);
        run_instr(7'h33, 3'd6, 1'b0, 1'b0, 0);
        run_instr(7'h13, 3'd0, 1'b1, 1'b0, 0);
        run_instr(7'h63, 3'd0, 1'b0, 1'b1, 0);
        run_instr(7'h63, 3'd0, 1'b0, 1'b0, 0);
        run_instr(7'h6f, 3'd0, 1'b0, 1'b0, 0);
        run_instr(7'h00, 3'd0, 1'b0, 1'b1, 0);
        run_instr(7'h23, 3'd0, 1'b0, 1'b0, 2);
        sw_wait2();
        reset_mid_store();

        for (int n = 0; n < 300; n++) begin
            run_instr(ops[$urandom_range(7, 0)], 3'($urandom),
                      1'($urandom), 1'($urandom), 3);
        end
        #2;
        check("final_state", 32'(o_state), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
